// File: rtl/id_hazard_ctrl.sv
// IF/ID control: branch/jump resolution in ID plus load-use and branch-operand stalls.
// Optional HZD_PERF_CNT_EN adds stall_cycles/flush_count performance counters.
module id_hazard_ctrl #(
    parameter int unsigned ADDR_W    = 32,  // must be >= 29 for the j target concatenation
    parameter int unsigned MAX_STALL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Instruction_in,
    input  logic [ADDR_W-1:0] Next_Address_in,
    input  logic              rs_eq,
    input  logic              idex_memread,
    input  logic              idex_regwrite,
    input  logic [4:0]        idex_dst,
    input  logic              exmem_memread,
    input  logic [4:0]        exmem_dst,
    input  logic              ext_stall,
    output logic              PCWrite,
    output logic              hzdetect,
    output logic              freeze,
    output logic              flush,
    output logic              PCSrc,
    output logic [ADDR_W-1:0] Branch_Address,
`ifdef HZD_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count,
`endif
    output logic              idex_bubble
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [1:0] MaxStall = 2'(MAX_STALL);

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        is_beq, is_bne, is_j, is_branch, uses_rt;
    logic        rs_live, rt_live;
    logic        load_use, br_idex, br_exmem, hazard, taken;
    logic [1:0]  n_raw, n_stall;
    logic [1:0]  stall_cnt_d, stall_cnt_q;
    logic [ADDR_W-1:0] br_off;

    assign op  = Instruction_in[31:26];
    assign rs  = Instruction_in[25:21];
    assign rt  = Instruction_in[20:16];
    assign imm = Instruction_in[15:0];

    assign is_beq    = (op == OpBeq);
    assign is_bne    = (op == OpBne);
    assign is_j      = (op == OpJ);
    assign is_branch = is_beq | is_bne;
    assign uses_rt   = (op == OpRtype) | is_branch | (op == OpSw);

    // $0 is hard-wired, and j carries no register operands
    assign rs_live = (rs != 5'd0) & ~is_j;
    assign rt_live = (rt != 5'd0) & uses_rt;

    assign load_use = idex_memread & ((rs_live & (idex_dst == rs)) |
                                      (rt_live & (idex_dst == rt)));
    assign br_idex  = is_branch & idex_regwrite & ((rs_live & (idex_dst == rs)) |
                                                   (rt_live & (idex_dst == rt)));
    assign br_exmem = is_branch & exmem_memread & ((rs_live & (exmem_dst == rs)) |
                                                   (rt_live & (exmem_dst == rt)));

    always_comb begin
        n_raw = 2'd0;
        if (load_use || br_idex || br_exmem) n_raw = 2'd1;
        if (br_idex && idex_memread)         n_raw = 2'd2;
        n_stall = (n_raw > MaxStall) ? MaxStall : n_raw;
    end

    assign hazard = (n_raw != 2'd0);
    assign taken  = (is_beq & rs_eq) | (is_bne & ~rs_eq) | is_j;

    assign br_off = {{(ADDR_W - 18){imm[15]}}, imm, 2'b00};

    always_comb begin
        if (is_branch) begin
            Branch_Address = Next_Address_in + br_off;
        end else if (is_j) begin
            Branch_Address = {Next_Address_in[ADDR_W-1:28], Instruction_in[25:0], 2'b00};
        end else begin
            Branch_Address = Next_Address_in;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        PCWrite     = 1'b1;
        hzdetect    = 1'b0;
        freeze      = 1'b0;
        flush       = 1'b0;
        PCSrc       = 1'b0;
        idex_bubble = 1'b0;
        if (!rst) begin
            flush       = 1'b1;
            stall_cnt_d = 2'd0;
        end else if (ext_stall) begin
            PCWrite = 1'b0;
            freeze  = 1'b1;
        end else if (stall_cnt_q != 2'd0 || hazard) begin
            PCWrite     = 1'b0;
            hzdetect    = 1'b1;
            freeze      = 1'b1;
            idex_bubble = 1'b1;
            // the hazard cycle itself is the first of the N stall cycles
            stall_cnt_d = (stall_cnt_q != 2'd0) ? stall_cnt_q - 2'd1 : n_stall - 2'd1;
        end else if (taken) begin
            PCSrc = 1'b1;
            flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 2'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef HZD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (hzdetect) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (PCSrc)    flush_count_q  <= flush_count_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl (default build, counters off unless
// HZD_PERF_CNT_EN is defined).
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instruction_in;
    logic [31:0] Next_Address_in;
    logic        rs_eq, idex_memread, idex_regwrite, exmem_memread, ext_stall;
    logic [4:0]  idex_dst, exmem_dst;
    logic        PCWrite, hzdetect, freeze, flush, PCSrc, idex_bubble;
    logic [31:0] Branch_Address;
`ifdef HZD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // {PCWrite, hzdetect, freeze, flush, PCSrc, idex_bubble}
    logic [5:0] ctl;
    assign ctl = {PCWrite, hzdetect, freeze, flush, PCSrc, idex_bubble};

    localparam logic [5:0] CNorm  = 6'b100000;
    localparam logic [5:0] CRst   = 6'b100100;
    localparam logic [5:0] CStall = 6'b011001;
    localparam logic [5:0] CExt   = 6'b001000;
    localparam logic [5:0] CTaken = 6'b100110;

    localparam logic [31:0] Nop      = 32'h0000_0000;
    localparam logic [31:0] Add9810  = {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] Add9010  = {6'd0, 5'd0, 5'd10, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] Lw10     = {6'b100011, 5'd8, 5'd10, 16'h0000};
    localparam logic [31:0] Sw10     = {6'b101011, 5'd8, 5'd10, 16'h0000};
    localparam logic [31:0] Beq89Neg = {6'b000100, 5'd8, 5'd9, 16'hFFFE};
    localparam logic [31:0] Beq89P1  = {6'b000100, 5'd8, 5'd9, 16'h0001};
    localparam logic [31:0] Bne89P4  = {6'b000101, 5'd8, 5'd9, 16'h0004};
    localparam logic [31:0] J40      = {6'b000010, 26'h000_0040};
    localparam logic [31:0] JMax     = {6'b000010, 26'h3FF_FFFF};

    always #5 clk = ~clk;

    id_hazard_ctrl #(.ADDR_W(32), .MAX_STALL(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .Instruction_in (Instruction_in),
        .Next_Address_in(Next_Address_in),
        .rs_eq          (rs_eq),
        .idex_memread   (idex_memread),
        .idex_regwrite  (idex_regwrite),
        .idex_dst       (idex_dst),
        .exmem_memread  (exmem_memread),
        .exmem_dst      (exmem_dst),
        .ext_stall      (ext_stall),
        .PCWrite        (PCWrite),
        .hzdetect       (hzdetect),
        .freeze         (freeze),
        .flush          (flush),
        .PCSrc          (PCSrc),
        .Branch_Address (Branch_Address),
`ifdef HZD_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
`endif
        .idex_bubble    (idex_bubble)
    );

    // Move to 1 time unit after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        Instruction_in  = Nop;
        Next_Address_in = 32'h0000_0004;
        rs_eq           = 1'b0;
        idex_memread    = 1'b0;
        idex_regwrite   = 1'b0;
        idex_dst        = 5'd0;
        exmem_memread   = 1'b0;
        exmem_dst       = 5'd0;
        ext_stall       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_pipe();
        #2;
        n_total++; if (ctl !== CRst) $display("FAIL reset_c0: ctl=%b exp=%b", ctl, CRst); else n_pass++;
        tick();
        idex_memread = 1'b1; idex_dst = 5'd8; Instruction_in = Add9810;
        #1;
        n_total++; if (ctl !== CRst) $display("FAIL reset_over_hazard: ctl=%b exp=%b", ctl, CRst); else n_pass++;
        tick();
        rst = 1'b1;
        clear_pipe();
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL reset_release: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        idex_memread = 1'b1; idex_dst = 5'd8; Instruction_in = Add9810;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL load_use_rs: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        idex_memread = 1'b0;
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL load_use_after: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
        idex_memread = 1'b1; idex_dst = 5'd10; Instruction_in = Sw10;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL load_use_sw_rt: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        Instruction_in = Lw10;
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL lw_rt_no_use: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
        idex_dst = 5'd0; Instruction_in = Add9010;
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL reg0_no_hazard: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
        clear_pipe();
    endtask

    task automatic test_branch_after_load();
        Instruction_in = Beq89Neg; Next_Address_in = 32'h0000_0100;
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_dst = 5'd9;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL br_load_c0: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_dst = 5'd0;
        exmem_memread = 1'b1; exmem_dst = 5'd9;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL br_load_c1: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        exmem_memread = 1'b0; exmem_dst = 5'd0; rs_eq = 1'b1;
        #1;
        n_total++; if (ctl !== CTaken) $display("FAIL br_load_taken: ctl=%b exp=%b", ctl, CTaken); else n_pass++;
        n_total++; if (Branch_Address !== 32'h0000_00F8)
            $display("FAIL br_target_neg: got=%h exp=%h", Branch_Address, 32'h0000_00F8); else n_pass++;
        tick();
        // EX/MEM load feeding a branch: single stall, then not-taken
        clear_pipe();
        Instruction_in = Beq89Neg; exmem_memread = 1'b1; exmem_dst = 5'd8;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL br_exmem_c0: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        exmem_memread = 1'b0; rs_eq = 1'b0;
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL br_exmem_after: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
        // ALU result in ID/EX feeding a branch: single stall
        idex_regwrite = 1'b1; idex_dst = 5'd8;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL br_alu_c0: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        idex_regwrite = 1'b0;
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL br_alu_after: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
        Instruction_in = Beq89P1; Next_Address_in = 32'hFFFF_FFFC; rs_eq = 1'b1;
        #1;
        n_total++; if (Branch_Address !== 32'h0000_0000)
            $display("FAIL br_target_wrap: got=%h exp=%h", Branch_Address, 32'h0); else n_pass++;
        n_total++; if (ctl !== CTaken) $display("FAIL br_wrap_taken: ctl=%b exp=%b", ctl, CTaken); else n_pass++;
        tick();
        clear_pipe();
    endtask

    task automatic test_jump();
        Instruction_in = J40; Next_Address_in = 32'h4000_0010;
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_dst = 5'd0;
        #1;
        n_total++; if (ctl !== CTaken) $display("FAIL j_ctl: ctl=%b exp=%b", ctl, CTaken); else n_pass++;
        n_total++; if (Branch_Address !== 32'h4000_0100)
            $display("FAIL j_target: got=%h exp=%h", Branch_Address, 32'h4000_0100); else n_pass++;
        tick();
        Instruction_in = JMax; idex_dst = 5'd31;
        #1;
        n_total++; if (ctl !== CTaken) $display("FAIL j_no_stall: ctl=%b exp=%b", ctl, CTaken); else n_pass++;
        n_total++; if (Branch_Address !== 32'h4FFF_FFFC)
            $display("FAIL j_target_max: got=%h exp=%h", Branch_Address, 32'h4FFF_FFFC); else n_pass++;
        tick();
        clear_pipe();
    endtask

    task automatic test_bne();
        Instruction_in = Bne89P4; Next_Address_in = 32'h0000_0200; rs_eq = 1'b1;
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL bne_not_taken: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        n_total++; if (Branch_Address !== 32'h0000_0210)
            $display("FAIL bne_target: got=%h exp=%h", Branch_Address, 32'h0000_0210); else n_pass++;
        tick();
        rs_eq = 1'b0;
        #1;
        n_total++; if (ctl !== CTaken) $display("FAIL bne_taken: ctl=%b exp=%b", ctl, CTaken); else n_pass++;
        tick();
        clear_pipe();
    endtask

    task automatic test_ext_stall_mid();
        Instruction_in = Beq89Neg; idex_memread = 1'b1; idex_regwrite = 1'b1; idex_dst = 5'd9;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL ext_mid_c0: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_dst = 5'd0; ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (ctl !== CExt) $display("FAIL ext_hold_%0d: ctl=%b exp=%b", i, ctl, CExt); else n_pass++;
            tick();
        end
        ext_stall = 1'b0;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL ext_resume: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL ext_done: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
        // ext_stall over a fresh hazard must not load the counter
        Instruction_in = Add9810; idex_memread = 1'b1; idex_dst = 5'd8; ext_stall = 1'b1;
        #1;
        n_total++; if (ctl !== CExt) $display("FAIL ext_over_hazard: ctl=%b exp=%b", ctl, CExt); else n_pass++;
        tick();
        idex_memread = 1'b0; ext_stall = 1'b0;
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL ext_no_load: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
        clear_pipe();
    endtask

    task automatic test_reset_mid_stall();
        Instruction_in = Beq89Neg; idex_memread = 1'b1; idex_regwrite = 1'b1; idex_dst = 5'd9;
        #1;
        n_total++; if (ctl !== CStall) $display("FAIL rst_mid_c0: ctl=%b exp=%b", ctl, CStall); else n_pass++;
        tick();
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_dst = 5'd0; rst = 1'b0;
        #1;
        n_total++; if (ctl !== CRst) $display("FAIL rst_mid_c1: ctl=%b exp=%b", ctl, CRst); else n_pass++;
        tick();
        rst = 1'b1;
        clear_pipe();
        #1;
        n_total++; if (ctl !== CNorm) $display("FAIL rst_mid_abort: ctl=%b exp=%b", ctl, CNorm); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_jump();
        test_bne();
        test_ext_stall_mid();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Control end of the IF/ID interface.
- Watches the instruction held in IF2ID and the downstream pipeline state.
- Generates the fetch-side controls: PCWrite, hzdetect, freeze, flush, PCSrc and Branch_Address.
- Resolves branches and jumps in ID, and inserts load-use and branch-operand stalls using a registered stall counter.

Parameters:
- ADDR_W, 32, width of PC, Next_Address and Branch_Address.
- MAX_STALL, 2, largest stall count loaded by one hazard (range 1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- Instruction_in  in  32  instruction from IF2ID.
- Next_Address_in  in  ADDR_W  PC+4 from IF2ID.
- rs_eq  in  1  ID comparator: reg[rs]==reg[rt].
- idex_memread  in  1  ID/EX holds a load.
- idex_regwrite  in  1  ID/EX writes a register.
- idex_dst  in  5  ID/EX destination register.
- exmem_memread  in  1  EX/MEM holds a load.
- exmem_dst  in  5  EX/MEM destination register.
- ext_stall  in  1  data-memory wait; freeze whole front end.
- PCWrite  out  1  1 = PC updates.
- hzdetect  out  1  1 = hazard stall active.
- freeze  out  1  1 = IF2ID holds.
- flush  out  1  1 = IF2ID loads NOP (0).
- PCSrc  out  1  1 = PC takes Branch_Address.
- Branch_Address  out  ADDR_W  redirect target.
- idex_bubble  out  1  1 = zero controls into ID/EX.

Behaviour:
- Decode: op=Instruction_in[31:26], rs=[25:21], rt=[20:16], imm=[15:0].
- Opcodes: R-type 000000, beq 000100, bne 000101, j 000010, lw 100011, sw 101011.
- uses_rt is true for R-type, beq, bne, sw.
- Register 0 never causes a hazard.
- Sequential state: stall_cnt[1:0] only. All outputs are combinational from stall_cnt and the inputs.
- Reset (rst=0 at clk edge): stall_cnt<=0.
  - While rst=0, outputs are PCWrite=1, flush=1, and hzdetect=freeze=PCSrc=idex_bubble=0.
- Priority, highest first: reset > ext_stall > active stall (stall_cnt!=0) > new hazard > branch redirect > normal.
- ext_stall=1:
  - PCWrite=0, freeze=1; flush=PCSrc=hzdetect=idex_bubble=0.
  - stall_cnt holds.
- Stall outputs (active stall or new hazard): PCWrite=0, hzdetect=1, freeze=1, idex_bubble=1, flush=0, PCSrc=0.
- Active stall: stall outputs; stall_cnt<=stall_cnt-1.
- New hazard with stall_cnt==0, N = max over the conditions below, clamped to MAX_STALL:
  - Load-use: idex_memread && idex_dst==rs, or idex_memread && uses_rt && idex_dst==rt. N=1 for a non-branch.
  - Branch (beq/bne) operand from ID/EX: idex_regwrite && idex_dst in {rs,rt}. N=1, or N=2 if idex_memread.
  - Branch operand from EX/MEM load: exmem_memread && exmem_dst in {rs,rt}. N=1.
  - Action: stall outputs; stall_cnt<=N-1.
  - Once stall_cnt returns to 0, hazards are re-evaluated on live inputs.
- Branch redirect (no stall, no ext_stall):
  - Taken = (beq && rs_eq) || (bne && !rs_eq) || j.
  - Taken: PCSrc=1, PCWrite=1, flush=1 (kill the wrong-path fetch), freeze=0.
  - Not taken: normal outputs.
- Target:
  - beq/bne: Next_Address_in + (sign_extend(imm)<<2), modulo 2^ADDR_W (wrap allowed).
  - j: {Next_Address_in[31:28], Instruction_in[25:0], 2'b00}.
  - Otherwise Branch_Address=Next_Address_in.
  - Branch_Address is valid every cycle; it is only used when PCSrc=1.
- Normal: PCWrite=1, all other controls 0.
- j never stalls (no register operands).
- ext_stall arriving mid-stall suspends the countdown; the countdown resumes when ext_stall drops.
- rst=0 mid-stall aborts the stall immediately.

Optional Feature:
- Macro HZD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments on every cycle hzdetect=1.
  - flush_count increments on every taken redirect.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst=0 for 2 cycles -> PCWrite=1, flush=1, PCSrc=0. Then rst=1 with a NOP -> all controls 0, PCWrite=1.
- Load-use: idex_memread=1, idex_dst=8, Instruction_in=add $9,$8,$10 -> exactly 1 cycle of hzdetect=1, freeze=1, PCWrite=0, idex_bubble=1. Then normal once idex_memread=0.
- Branch after load: beq $8,$9 with idex_memread=1, idex_regwrite=1, idex_dst=9 -> 2 stall cycles. Then rs_eq=1, Next_Address_in=0x100, imm=0xFFFE -> PCSrc=1, flush=1, Branch_Address=0xF8.
- Jump: j with target field 0x0000040, Next_Address_in=0x40000010 -> Branch_Address=0x40000100, PCSrc=1, flush=1, no stall.
- bne not taken: rs_eq=1 -> PCSrc=0, flush=0, PCWrite=1.
- ext_stall=1 during the second cycle of a 2-cycle stall for 3 cycles -> freeze=1, hzdetect=0, stall_cnt held. Then one more hazard stall cycle, then normal. Repeat with rst=0 mid-stall -> stall aborted.
